// File: rtl/req_gnt_responder_if.sv
// Request/grant handshake bundle between a requester and req_gnt_responder.
// master: the requester side (drives req, reports resource readiness on avail).
// slave:  the responder side (returns gnt plus status pulses).
interface req_gnt_responder_if;
  logic req;
  logic avail;
  logic gnt;
  logic busy;
  logic late;
  logic drop;

  modport master (
    output req,
    output avail,
    input  gnt,
    input  busy,
    input  late,
    input  drop
  );

  modport slave (
    input  req,
    input  avail,
    output gnt,
    output busy,
    output late,
    output drop
  );
endinterface

// File: rtl/req_gnt_responder.sv
// Grant side of the req/gnt handshake.
// A sampled req starts a request at cycle 0. gnt is held off for MIN_GAP cycles, then issued
// exactly once inside the next WIN cycles: one cycle after avail is seen, or forced (with late)
// at the last window cycle. All outputs are registered.
// Optional feature: define REQ_QUEUE_EN for a one-deep pending request register; without it,
// every req arriving while busy is discarded with a drop pulse.
module req_gnt_responder #(
  parameter int unsigned MIN_GAP = 3,
  parameter int unsigned WIN     = 8,
  parameter int unsigned CNT_W   = 4
) (
  input logic                clk,
  input logic                rst,
  req_gnt_responder_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if ((2 ** CNT_W) <= (MIN_GAP + WIN)) begin : g_cnt_w_chk
    $error("req_gnt_responder: CNT_W too narrow, need 2**CNT_W > MIN_GAP+WIN");
  end
  if (MIN_GAP < 1) begin : g_min_gap_chk
    $error("req_gnt_responder: MIN_GAP must be at least 1");
  end
  if (WIN < 1) begin : g_win_chk
    $error("req_gnt_responder: WIN must be at least 1");
  end

  // Counter landmarks; cnt equals the cycle number of the request being served.
  localparam logic [CNT_W-1:0] OneCnt     = CNT_W'(1);
  localparam logic [CNT_W-1:0] GapLastCnt = CNT_W'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] WinLastCnt = CNT_W'(MIN_GAP + WIN - 1);
  localparam logic [CNT_W-1:0] MaxCnt     = CNT_W'(MIN_GAP + WIN);

  // StGrant is the cycle gnt is visible; StDone is the cycle after it, which still treats an
  // incoming req as arriving while busy (and, with the queue, may restart immediately).
  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StWindow,
    StGrant,
    StDone
  } state_e;

  // With MIN_GAP==1 cycle 1 already belongs to the window, so the gap state is skipped.
  localparam state_e AcceptSt = state_e'((MIN_GAP == 1) ? StWindow : StGap);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             late_q, late_d;
  logic             drop_q, drop_d;

  logic             in_flight;
  logic             at_deadline;
  logic             done_take;
  logic             accept;

`ifdef REQ_QUEUE_EN
  logic             pending_q, pending_d;
`endif

  // A request is outstanding from the first gap cycle through the grant cycle.
  assign in_flight   = (state_q == StGap) || (state_q == StWindow) || (state_q == StGrant);
  assign at_deadline = (state_q == StWindow) && (cnt_q == WinLastCnt);

`ifdef REQ_QUEUE_EN
  // In the post-grant cycle a held request, or a fresh req if nothing is held, starts anew.
  assign done_take = pending_q || bus.req;
`else
  assign done_take = 1'b0;
`endif

  assign accept = ((state_q == StIdle) && bus.req) || ((state_q == StDone) && done_take);

  // State, counter, pending flag and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
      late_q    <= 1'b0;
      drop_q    <= 1'b0;
`ifdef REQ_QUEUE_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      late_q    <= late_d;
      drop_q    <= drop_d;
`ifdef REQ_QUEUE_EN
      pending_q <= pending_d;
`endif
    end
  end

  // Next-state, cycle counter and pending-request bookkeeping.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req) state_d = AcceptSt;
      end
      StGap: begin
        // Leave the gap so that the cycle with cnt==MIN_GAP already samples avail.
        if (cnt_q == GapLastCnt) state_d = StWindow;
      end
      StWindow: begin
        if (bus.avail || at_deadline) state_d = StGrant;
      end
      StGrant: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = accept ? AcceptSt : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Saturating counter: restarts at 1 on acceptance, never wraps.
    if (accept) begin
      cnt_d = OneCnt;
    end else if (in_flight) begin
      cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + OneCnt;
    end else begin
      cnt_d = '0;
    end

`ifdef REQ_QUEUE_EN
    pending_d = pending_q;
    if (state_q == StDone) begin
      // Either the held request is being accepted now or nothing was held.
      pending_d = 1'b0;
    end else if (in_flight && bus.req) begin
      pending_d = 1'b1;
    end
`endif
  end

  // Output decode, registered on the next edge.
  always_comb begin
    gnt_d  = (state_q == StWindow) && (bus.avail || at_deadline);
    late_d = at_deadline && !bus.avail;
`ifdef REQ_QUEUE_EN
    // busy does not dip when a held request is about to restart straight after the grant.
    busy_d = (state_d == StGap) || (state_d == StWindow) || (state_d == StGrant) ||
             ((state_d == StDone) && pending_d);
    drop_d = bus.req && pending_q && (in_flight || (state_q == StDone));
`else
    busy_d = (state_d == StGap) || (state_d == StWindow) || (state_d == StGrant);
    drop_d = bus.req && (in_flight || (state_q == StDone));
`endif
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.late = late_q;
  assign bus.drop = drop_q;

endmodule
